// File: rtl/fetch_pkg.sv
// fetch_pkg: shared defaults, queue-entry layout and sizing helper for the fetch stage
package fetch_pkg;
   localparam int XLEN_DEF = 16;
   localparam int RESET_PC_DEF = 0;
   typedef struct packed {
      logic [XLEN_DEF-1:0] pc;
      logic [XLEN_DEF-1:0] ir;
      logic [XLEN_DEF-1:0] pc_inc;
   } fetch_entry_t;
   // ceil(log2(n)), never below 1 so single-source/entry buses keep a bit
   function automatic int clog2(input int n);
      int r = 0;
      for (int i = 0; i < 31; i++) if ((1 << i) < n) r = i + 1;
      return (r == 0) ? 1 : r;
   endfunction
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: flushable synchronous FIFO; flush beats push and pop in the same cycle
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int W = $bits(fetch_entry_t),
   parameter int DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    push_i,
   input  logic                    pop_i,
   input  logic                    flush_i,
   input  logic [W-1:0]            din_i,
   output logic [W-1:0]            head_o,
   output logic [clog2(DEPTH):0]   count_o,
   output logic                    full_o,
   output logic                    empty_o
);
   localparam int AW = clog2(DEPTH);
   localparam int CW = AW + 1;
   logic [W-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [CW-1:0] cnt_q, cnt_d;
   assign cnt_d = cnt_q + CW'(push_i) - CW'(pop_i);
   always_ff @(posedge clk) begin
      if (reset || flush_i) begin
         wr_q <= '0;
         rd_q <= '0;
         cnt_q <= '0;
      end else begin
         wr_q <= wr_q + AW'(push_i);
         rd_q <= rd_q + AW'(pop_i);
         cnt_q <= cnt_d;
      end
   end
   always_ff @(posedge clk) if (push_i) mem_q[wr_q] <= din_i;
   assign head_o = mem_q[rd_q];
   assign count_o = cnt_q;
   assign full_o = cnt_q == CW'(DEPTH);
   assign empty_o = cnt_q == '0;
endmodule

// File: rtl/fetch_redirect_queue.sv
// fetch_redirect_queue: PC register with fixed-priority redirect and a decoupling fetch queue
module fetch_redirect_queue
   import fetch_pkg::*;
#(
   parameter int XLEN = XLEN_DEF,
   parameter int NUM_SRC = 6,
   parameter int DEPTH = 4,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_SRC-1:0]         redir_valid,
   input  logic [NUM_SRC*XLEN-1:0]    redir_target,
   input  logic                       pc_write,
   output logic [XLEN-1:0]            imem_addr,
   input  logic [XLEN-1:0]            imem_rdata,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [XLEN-1:0]            out_ir,
   output logic [XLEN-1:0]            out_pc,
   output logic [XLEN-1:0]            out_pc_inc,
   output logic [clog2(DEPTH):0]      fifo_count,
   output logic                       redirect_taken,
   output logic [clog2(NUM_SRC)-1:0]  redirect_src
);
   localparam int SW = clog2(NUM_SRC);
   logic [XLEN-1:0] pc_q, pc_d, pc_inc, tgt;
   logic [SW-1:0] win, src_q;
   logic taken_q, redir, enq, deq, full, empty;
   logic [3*XLEN-1:0] head;
   // scan downwards so the lowest set index wins
   always_comb begin
      win = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) if (redir_valid[i]) win = SW'(i);
   end
   assign redir = |redir_valid;
   assign tgt = redir_target[win*XLEN +: XLEN];
   assign pc_inc = pc_q + XLEN'(1);
   assign out_valid = !empty && !redir;
   assign deq = out_valid && out_ready;
   assign enq = !redir && pc_write && (!full || deq);
   assign pc_d = redir ? tgt : enq ? pc_inc : pc_q;
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q <= RESET_PC;
         taken_q <= 1'b0;
         src_q <= '0;
      end else begin
         pc_q <= pc_d;
         taken_q <= redir;
         src_q <= redir ? win : '0;
      end
   end
   fetch_queue #(.W(3*XLEN), .DEPTH(DEPTH)) u_queue (
      .clk(clk),
      .reset(reset),
      .push_i(enq),
      .pop_i(deq),
      .flush_i(redir),
      .din_i({pc_q, imem_rdata, pc_inc}),
      .head_o(head),
      .count_o(fifo_count),
      .full_o(full),
      .empty_o(empty)
   );
   assign {out_pc, out_ir, out_pc_inc} = head;
   assign imem_addr = pc_q;
   assign redirect_taken = taken_q;
   assign redirect_src = src_q;
endmodule

// File: tb/tb_fetch_redirect_queue.sv
// tb_fetch_redirect_queue: directed vectors against hand-computed fetch/queue/redirect behaviour
module tb_fetch_redirect_queue;
   logic clk = 1'b0, reset = 1'b1, pc_write = 1'b0, out_ready = 1'b0;
   logic [5:0] redir_valid = '0;
   logic [95:0] redir_target = '0;
   logic [15:0] imem_addr, imem_rdata, out_ir, out_pc, out_pc_inc;
   logic out_valid, redirect_taken;
   logic [2:0] fifo_count, redirect_src;
   int errors = 0, checks = 0;

   fetch_redirect_queue dut (
      .clk(clk), .reset(reset), .redir_valid(redir_valid), .redir_target(redir_target),
      .pc_write(pc_write), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .out_valid(out_valid), .out_ready(out_ready), .out_ir(out_ir), .out_pc(out_pc),
      .out_pc_inc(out_pc_inc), .fifo_count(fifo_count), .redirect_taken(redirect_taken),
      .redirect_src(redirect_src)
   );

   assign imem_rdata = imem_addr + 16'h1000;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      tick(2);
      reset = 1'b0;
      check("rst_pc", imem_addr, 16'h0000);
      check("rst_valid", out_valid, 0);
      check("rst_count", fifo_count, 0);
      check("rst_taken", redirect_taken, 0);
      check("rst_src", redirect_src, 0);

      pc_write = 1'b1;
      tick(1);
      check("lat_valid", out_valid, 1);
      check("lat_count", fifo_count, 1);
      tick(3);
      check("fill_count", fifo_count, 4);
      check("fill_pc", imem_addr, 16'h0004);
      check("fill_head_pc", out_pc, 16'h0000);
      check("fill_head_ir", out_ir, 16'h1000);
      check("fill_head_inc", out_pc_inc, 16'h0001);
      tick(1);
      check("stall_pc", imem_addr, 16'h0004);
      check("stall_count", fifo_count, 4);

      out_ready = 1'b1;
      tick(1);
      check("drain1_pc", imem_addr, 16'h0005);
      check("drain1_count", fifo_count, 4);
      check("drain1_head", out_pc, 16'h0001);
      tick(1);
      check("drain2_pc", imem_addr, 16'h0006);
      check("drain2_count", fifo_count, 4);
      check("drain2_ir", out_ir, 16'h1002);

      pc_write = 1'b0;
      tick(1);
      check("three_count", fifo_count, 3);
      out_ready = 1'b0;
      redir_valid = 6'b100100;
      redir_target[2*16 +: 16] = 16'h0040;
      redir_target[5*16 +: 16] = 16'h0080;
      #1;
      check("redir_valid_kill", out_valid, 0);
      tick(1);
      redir_valid = '0;
      #1;
      check("redir_pc", imem_addr, 16'h0040);
      check("redir_count", fifo_count, 0);
      check("redir_taken", redirect_taken, 1);
      check("redir_src", redirect_src, 2);
      check("redir_empty", out_valid, 0);
      tick(1);
      check("redir_clear_taken", redirect_taken, 0);
      check("redir_clear_src", redirect_src, 0);

      redir_valid = 6'b000001;
      redir_target[0 +: 16] = 16'hFFFF;
      tick(1);
      redir_valid = '0;
      check("wrap_pc", imem_addr, 16'hFFFF);
      check("wrap_taken", redirect_taken, 1);
      check("wrap_src", redirect_src, 0);
      pc_write = 1'b1;
      tick(2);
      pc_write = 1'b0;
      check("wrap_count", fifo_count, 2);
      check("wrap_nextpc", imem_addr, 16'h0001);
      check("wrap_head_pc", out_pc, 16'hFFFF);
      check("wrap_head_ir", out_ir, 16'h0FFF);
      check("wrap_head_inc", out_pc_inc, 16'h0000);
      out_ready = 1'b1;
      tick(1);
      out_ready = 1'b0;
      check("wrap2_pc", out_pc, 16'h0000);
      check("wrap2_inc", out_pc_inc, 16'h0001);
      check("wrap2_ir", out_ir, 16'h1000);

      pc_write = 1'b1;
      tick(3);
      check("pre_rst_count", fifo_count, 4);
      reset = 1'b1;
      redir_valid = 6'b000001;
      redir_target[0 +: 16] = 16'h0123;
      out_ready = 1'b1;
      tick(1);
      reset = 1'b0;
      redir_valid = '0;
      pc_write = 1'b0;
      out_ready = 1'b0;
      #1;
      check("mid_rst_pc", imem_addr, 16'h0000);
      check("mid_rst_count", fifo_count, 0);
      check("mid_rst_taken", redirect_taken, 0);
      check("mid_rst_valid", out_valid, 0);
      pc_write = 1'b1;
      tick(1);
      check("post_rst_head", out_pc, 16'h0000);
      check("post_rst_count", fifo_count, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
